// File: rtl/ibex_pkg.sv
// Shared fetch-side constants and requester identifiers for the instruction bus arbiter.
package ibex_pkg;

  localparam int unsigned IBEX_INSTR_ARB_NUM_REQ = 2;

  typedef enum logic [0:0] {
    ARB_REQ_FETCH = 1'b0,
    ARB_REQ_AUX   = 1'b1
  } ibex_instr_arb_req_e;

endpackage

// File: rtl/ibex_instr_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered bus transactions.
module ibex_instr_arb_id_fifo #(
  parameter  int unsigned Depth = 2,
  parameter  int unsigned Width = 1,
  localparam int unsigned CntW  = $clog2(Depth + 1),
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_id_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_id_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign full_o    = (cnt_q == CntW'(Depth));
  assign empty_o   = (cnt_q == '0);
  assign head_id_o = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) push_i |-> !full_o);

endmodule

// File: rtl/ibex_instr_bus_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port, with in-order response routing.
module ibex_instr_bus_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned NumReq         = IBEX_INSTR_ARB_NUM_REQ,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumReq-1:0]    req_i,
  input  logic [NumReq*32-1:0] addr_i,
  output logic [NumReq-1:0]    gnt_o,
  output logic [NumReq-1:0]    rvalid_o,
  output logic [31:0]          rdata_o,
  output logic [NumReq-1:0]    err_o,
  output logic                 instr_req_o,
  input  logic                 instr_gnt_i,
  output logic [31:0]          instr_addr_o,
  input  logic                 instr_rvalid_i,
  input  logic [31:0]          instr_rdata_i,
  input  logic                 instr_err_i,
  output logic                 busy_o
);

  localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d, owner_q, owner_d, winner, cur_owner, head_id;
  logic            lock_q, lock_d, seen_gnt_q, seen_gnt_d, found;
  logic            push, pop, fifo_full, fifo_empty;
  logic [CntW-1:0] count;
  logic [31:0]     addr_sel;
  int unsigned     base_idx, scan_idx;

  ibex_instr_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push),
    .push_id_i (cur_owner),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_id_o (head_id),
    .count_o   (count)
  );

  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    base_idx = {{(32 - IdW){1'b0}}, rr_ptr_q};
    for (int unsigned i = 0; i < NumReq; i++) begin
      scan_idx = (base_idx + i) % NumReq;
      if (!found && req_i[scan_idx]) begin
        winner = IdW'(scan_idx);
        found  = 1'b1;
      end
    end

    // A locked owner stays on the bus even if it drops req_i; full cannot occur while locked.
    cur_owner   = lock_q ? owner_q : winner;
    instr_req_o = lock_q | (found & ~fifo_full);

    addr_sel = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (IdW'(k) == cur_owner) addr_sel = addr_i[k*32 +: 32];
    end
    instr_addr_o = addr_sel & 32'hFFFF_FFFC;

    push  = instr_req_o & instr_gnt_i;
    gnt_o = '0;
    for (int unsigned k = 0; k < NumReq; k++) gnt_o[k] = push & (IdW'(k) == cur_owner);

    lock_d     = lock_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    seen_gnt_d = seen_gnt_q | push;
    if (push) begin
      lock_d   = 1'b0;
      rr_ptr_d = (cur_owner == IdW'(NumReq - 1)) ? '0 : cur_owner + IdW'(1);
    end else if (instr_req_o) begin
      lock_d  = 1'b1;
      owner_d = cur_owner;
    end

    pop      = instr_rvalid_i & ~fifo_empty;
    rvalid_o = '0;
    err_o    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      rvalid_o[k] = pop & (IdW'(k) == head_id);
      err_o[k]    = pop & (IdW'(k) == head_id) & instr_err_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      seen_gnt_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      seen_gnt_q <= seen_gnt_d;
    end
  end

  assign rdata_o = instr_rdata_i;
  assign busy_o  = (count != '0) | instr_req_o;

  // Stale responses are tolerated only until the first grant after reset.
  a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i) lock_q |-> $stable(instr_addr_o));
  a_gnt_onehot:  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));
  a_rv_onehot:   assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rvalid_o));
  a_no_stray_rv: assert property (@(posedge clk_i) disable iff (rst_i)
                                  (instr_rvalid_i & fifo_empty) |-> !seen_gnt_q);

endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// Scenario tests plus a randomized run against a queue-based reference model.
module tb_ibex_instr_bus_arbiter;
  import ibex_pkg::*;

  localparam int unsigned N    = 2;
  localparam int unsigned MAXO = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  req_i;
  logic [N*32-1:0] addr_i;
  logic [N-1:0]  gnt_o, rvalid_o, err_o;
  logic [31:0]   rdata_o, instr_addr_o, instr_rdata_i;
  logic          instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i, busy_o;

  int n_chk = 0;
  int n_err = 0;

  ibex_instr_bus_arbiter #(.NumReq(N), .MaxOutstanding(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc_start();
    @(posedge clk_i); #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    req_i = '0; addr_i = '0; instr_gnt_i = 0; instr_rvalid_i = 0;
    instr_rdata_i = '0; instr_err_i = 0;
  endtask

  task automatic do_reset();
    cyc_start(); rst_i = 1; idle_inputs();
    cyc_start(); rst_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; idle_inputs();
    settle();
    n_chk++; if (gnt_o !== 2'b00) begin n_err++; $display("FAIL reset_gnt got %b want 00", gnt_o); end
    n_chk++; if (rvalid_o !== 2'b00) begin n_err++; $display("FAIL reset_rvalid got %b want 00", rvalid_o); end
    n_chk++; if (err_o !== 2'b00) begin n_err++; $display("FAIL reset_err got %b want 00", err_o); end
    n_chk++; if (instr_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", instr_req_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
    cyc_start(); rst_i = 0;
  endtask

  task automatic test_single();
    do_reset();
    req_i = 2'b01; addr_i[31:0] = 32'h100; instr_gnt_i = 1;
    settle();
    n_chk++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL single_gnt got %b want 01", gnt_o); end
    n_chk++; if (instr_addr_o !== 32'h100) begin n_err++; $display("FAIL single_addr got %h want 100", instr_addr_o); end
    cyc_start(); idle_inputs();
    settle();
    n_chk++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", busy_o); end
    cyc_start(); instr_rvalid_i = 1; instr_rdata_i = 32'hDEADBEEF;
    settle();
    n_chk++; if (rvalid_o !== 2'b01) begin n_err++; $display("FAIL single_rvalid got %b want 01", rvalid_o); end
    n_chk++; if (rdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_rdata got %h want deadbeef", rdata_o); end
    cyc_start(); idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g, prev_g;
    do_reset();
    prev_g = 2'b00;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) cyc_start();
      req_i = (c < 4) ? 2'b11 : 2'b00; addr_i = {32'h2000, 32'h1000};
      instr_gnt_i = (c < 4); instr_rvalid_i = (c > 0); instr_rdata_i = 32'(c);
      exp_g = (c < 4) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      settle();
      n_chk++; if (gnt_o !== exp_g) begin n_err++; $display("FAIL b2b_gnt[%0d] got %b want %b", c, gnt_o, exp_g); end
      n_chk++; if (rvalid_o !== prev_g) begin n_err++; $display("FAIL b2b_rvalid[%0d] got %b want %b", c, rvalid_o, prev_g); end
      prev_g = exp_g;
    end
    cyc_start(); idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    req_i = 2'b10; addr_i[63:32] = 32'h204; instr_gnt_i = 0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin cyc_start(); req_i[0] = 1; addr_i[31:0] = 32'h300; end
      settle();
      n_chk++; if (instr_addr_o !== 32'h204) begin n_err++; $display("FAIL lock_addr[%0d] got %h want 204", c, instr_addr_o); end
      n_chk++; if (gnt_o !== 2'b00) begin n_err++; $display("FAIL lock_gnt[%0d] got %b want 00", c, gnt_o); end
    end
    cyc_start(); instr_gnt_i = 1;
    settle();
    n_chk++; if (gnt_o !== 2'b10) begin n_err++; $display("FAIL lock_release got %b want 10", gnt_o); end
    cyc_start(); addr_i[63:32] = 32'h208;
    settle();
    n_chk++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL lock_next got %b want 01", gnt_o); end
    n_chk++; if (instr_addr_o !== 32'h300) begin n_err++; $display("FAIL lock_next_addr got %h want 300", instr_addr_o); end
    cyc_start(); idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    req_i = 2'b11; addr_i = {32'h44, 32'h40}; instr_gnt_i = 1;
    settle();
    cyc_start(); settle();
    cyc_start(); settle();
    n_chk++; if (instr_req_o !== 1'b0) begin n_err++; $display("FAIL full_req got %b want 0", instr_req_o); end
    n_chk++; if (gnt_o !== 2'b00) begin n_err++; $display("FAIL full_gnt got %b want 00", gnt_o); end
    n_chk++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL full_busy got %b want 1", busy_o); end
    cyc_start(); instr_rvalid_i = 1;
    settle();
    n_chk++; if (instr_req_o !== 1'b0) begin n_err++; $display("FAIL full_req_rv got %b want 0", instr_req_o); end
    n_chk++; if (rvalid_o !== 2'b01) begin n_err++; $display("FAIL full_rvalid got %b want 01", rvalid_o); end
    cyc_start(); instr_rvalid_i = 0;
    settle();
    n_chk++; if (instr_req_o !== 1'b1) begin n_err++; $display("FAIL full_rearm got %b want 1", instr_req_o); end
    n_chk++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL full_rearm_gnt got %b want 01", gnt_o); end
    cyc_start(); idle_inputs();
  endtask

  task automatic test_error();
    do_reset();
    req_i = 2'b10; addr_i[63:32] = 32'h40; instr_gnt_i = 1;
    settle();
    n_chk++; if (gnt_o !== 2'b10) begin n_err++; $display("FAIL err_gnt got %b want 10", gnt_o); end
    cyc_start(); idle_inputs(); instr_rvalid_i = 1; instr_err_i = 1;
    settle();
    n_chk++; if (rvalid_o !== 2'b10) begin n_err++; $display("FAIL err_rvalid got %b want 10", rvalid_o); end
    n_chk++; if (err_o !== 2'b10) begin n_err++; $display("FAIL err_err got %b want 10", err_o); end
    cyc_start(); idle_inputs();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_i = 2'b10; addr_i = {32'h80, 32'h90}; instr_gnt_i = 1;
    settle();
    cyc_start(); req_i = 2'b01;
    settle();
    n_chk++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL mid_pre_gnt got %b want 01", gnt_o); end
    cyc_start(); rst_i = 1; idle_inputs();
    settle();
    n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b want 0", busy_o); end
    cyc_start(); rst_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'h5A5A;
    settle();
    n_chk++; if (rvalid_o !== 2'b00) begin n_err++; $display("FAIL mid_stray_rvalid got %b want 00", rvalid_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL mid_stray_busy got %b want 0", busy_o); end
    cyc_start(); idle_inputs(); req_i = 2'b11; addr_i = {32'h80, 32'h90}; instr_gnt_i = 1;
    settle();
    n_chk++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL mid_next_gnt got %b want 01", gnt_o); end
    cyc_start(); idle_inputs();
  endtask

  task automatic test_random();
    int          rr_m, hold_m, owner, head;
    int          q_m[$];
    bit          want[N];
    logic [31:0] adr_m[N];
    logic [1:0]  e_gnt, e_rv, e_err;
    logic [31:0] e_addr;
    bit          e_req, any;
    do_reset();
    rr_m = 0; hold_m = -1;
    for (int k = 0; k < N; k++) begin want[k] = 0; adr_m[k] = '0; end
    for (int c = 0; c < 400; c++) begin
      if (c > 0) cyc_start();
      for (int k = 0; k < N; k++) begin
        if (!want[k] && ($urandom_range(0, 2) != 0)) begin want[k] = 1; adr_m[k] = $urandom; end
        req_i[k] = want[k];
        addr_i[k*32 +: 32] = adr_m[k];
      end
      instr_gnt_i    = ($urandom_range(0, 2) != 0);
      instr_rvalid_i = (q_m.size() > 0) && ($urandom_range(0, 1) == 1);
      instr_rdata_i  = $urandom;
      instr_err_i    = $urandom_range(0, 1);

      owner = -1;
      if (hold_m >= 0) owner = hold_m;
      else if (q_m.size() < MAXO) begin
        for (int i = 0; i < N; i++)
          if (owner < 0 && want[(rr_m + i) % N]) owner = (rr_m + i) % N;
      end
      any    = 0;
      for (int k = 0; k < N; k++) any |= want[k];
      e_req  = (owner >= 0);
      e_addr = e_req ? (adr_m[owner] & 32'hFFFF_FFFC) : 32'h0;
      e_gnt  = (e_req && instr_gnt_i) ? 2'(1 << owner) : 2'b00;
      head   = (q_m.size() > 0) ? q_m[0] : 0;
      e_rv   = instr_rvalid_i ? 2'(1 << head) : 2'b00;
      e_err  = (instr_rvalid_i && instr_err_i) ? 2'(1 << head) : 2'b00;
      settle();
      n_chk++; if (instr_req_o !== e_req) begin n_err++; $display("FAIL rnd_req[%0d] got %b want %b", c, instr_req_o, e_req); end
      n_chk++; if (gnt_o !== e_gnt) begin n_err++; $display("FAIL rnd_gnt[%0d] got %b want %b", c, gnt_o, e_gnt); end
      if (e_req) begin
        n_chk++; if (instr_addr_o !== e_addr) begin n_err++; $display("FAIL rnd_addr[%0d] got %h want %h", c, instr_addr_o, e_addr); end
      end
      n_chk++; if (rvalid_o !== e_rv) begin n_err++; $display("FAIL rnd_rvalid[%0d] got %b want %b", c, rvalid_o, e_rv); end
      n_chk++; if (err_o !== e_err) begin n_err++; $display("FAIL rnd_err[%0d] got %b want %b", c, err_o, e_err); end
      n_chk++; if (busy_o !== ((q_m.size() != 0) || e_req)) begin n_err++; $display("FAIL rnd_busy[%0d] got %b q=%0d any=%b", c, busy_o, q_m.size(), any); end

      if (instr_rvalid_i) void'(q_m.pop_front());
      if (e_req && instr_gnt_i) begin
        q_m.push_back(owner);
        rr_m = (owner + 1) % N;
        hold_m = -1;
        want[owner] = 0;
      end else if (e_req) hold_m = owner;
    end
    cyc_start(); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lock();
    test_full();
    test_error();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
